// File: rtl/ascon_dec_ct_stage.sv
// ASCON-128 decryption ciphertext stage: holds the 320-bit state, absorbs CT beats and
// emits plaintext through a one-entry skid register. It sequences the external p6 between blocks.
module ascon_dec_ct_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [63:0] ld_s0,
  input  logic [63:0] ld_s1,
  input  logic [63:0] ld_s2,
  input  logic [63:0] ld_s3,
  input  logic [63:0] ld_s4,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [63:0] ct_data,
  input  logic        ct_last,
  input  logic [2:0]  ct_bytes,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [63:0] pt_data,
  output logic        pt_last,
  output logic [3:0]  pt_bytes,
  output logic [63:0] p_x0,
  output logic [63:0] p_x1,
  output logic [63:0] p_x2,
  output logic [63:0] p_x3,
  output logic [63:0] p_x4,
  input  logic [63:0] p_y0,
  input  logic [63:0] p_y1,
  input  logic [63:0] p_y2,
  input  logic [63:0] p_y3,
  input  logic [63:0] p_y4,
  output logic        st_valid,
  input  logic        st_ready,
  output logic [63:0] st_s0,
  output logic [63:0] st_s1,
  output logic [63:0] st_s2,
  output logic [63:0] st_s3,
  output logic [63:0] st_s4
);

  typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} state_t;

  state_t      state;
  logic [63:0] x0, x1, x2, x3, x4;
  logic        ct_fire;
  logic        pt_new;
  logic [63:0] last_mask;
  logic [63:0] last_pad;
  logic [63:0] pt_word;
  logic [63:0] x0_last;

  assign ld_ready = (state == IDLE);
  assign st_valid = (state == DONE);
  assign ct_ready = (state == ABSORB) && (!pt_valid || pt_ready);
  assign ct_fire  = ct_valid && ct_ready;
  // An empty last beat only pads the state; it carries no plaintext.
  assign pt_new   = ct_fire && (!ct_last || (ct_bytes != 3'd0));

  assign p_x0  = x0;
  assign p_x1  = x1;
  assign p_x2  = x2;
  assign p_x3  = x3;
  assign p_x4  = x4;
  assign st_s0 = x0;
  assign st_s1 = x1;
  assign st_s2 = x2;
  assign st_s3 = x3;
  assign st_s4 = x4;

  // With n=0 the mask is empty and the pad lands on bit 63, so one formula covers every last beat.
  always_comb begin
    last_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {ct_bytes, 3'b000});
    last_pad  = 64'h80 << {~ct_bytes, 3'b000};
    pt_word   = x0 ^ ct_data;
    x0_last   = ((ct_data & last_mask) | (x0 & ~last_mask)) ^ last_pad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x0       <= '0;
      x1       <= '0;
      x2       <= '0;
      x3       <= '0;
      x4       <= '0;
      pt_valid <= 1'b0;
      pt_data  <= '0;
      pt_last  <= 1'b0;
      pt_bytes <= '0;
    end else begin
      if (pt_new) begin
        pt_valid <= 1'b1;
        pt_last  <= ct_last;
        if (ct_last) begin
          pt_data  <= pt_word & last_mask;
          pt_bytes <= {1'b0, ct_bytes};
        end else begin
          pt_data  <= pt_word;
          pt_bytes <= 4'd8;
        end
      end else if (pt_valid && pt_ready) begin
        pt_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ld_valid) begin
            x0    <= ld_s0;
            x1    <= ld_s1;
            x2    <= ld_s2;
            x3    <= ld_s3;
            x4    <= ld_s4;
            state <= ABSORB;
          end
        end
        ABSORB: begin
          if (ct_fire) begin
            if (ct_last) begin
              x0    <= x0_last;
              state <= DONE;
            end else begin
              x0    <= ct_data;
              state <= PERM;
            end
          end
        end
        PERM: begin
          x0    <= p_y0;
          x1    <= p_y1;
          x2    <= p_y2;
          x3    <= p_y3;
          x4    <= p_y4;
          state <= ABSORB;
        end
        DONE: begin
          if (st_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
